// File: rtl/sram_boot_pkg.sv
// Shared types and constants for the power-up SRAM loader and its pin mux.
package sram_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ACK,
    WAIT_LOW,
    RELEASE,
    DONE
  } state_e;

  localparam int BYTES_PER_WORD     = 4;
  localparam int WRITE_PHASE_CYCLES = 3;

  // Byte 0 is the least significant byte and is written first.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/boot_sram_mux.sv
// SRAM pin select: the loader owns the pins until the ROM images are in place,
// after which the core drives them and sees read data.
module boot_sram_mux (
  input  logic        sel_core,
  input  logic [20:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        ld_oe,
  input  logic        ld_we_n,
  input  logic [20:0] core_addr,
  input  logic [7:0]  core_dout,
  input  logic        core_we_n,
  input  logic [7:0]  sram_data_in,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_data_out,
  output logic        sram_data_oe,
  output logic        sram_we_n,
  output logic [7:0]  core_din
);

  always_comb begin
    if (sel_core) begin
      sram_addr     = core_addr;
      sram_data_out = core_dout;
      sram_data_oe  = ~core_we_n;
      sram_we_n     = core_we_n;
      core_din      = sram_data_in;
    end else begin
      sram_addr     = ld_addr;
      sram_data_out = ld_data;
      sram_data_oe  = ld_oe;
      sram_we_n     = ld_we_n;
      core_din      = 8'hFF;
    end
  end

endmodule

// File: rtl/sram_boot_arbiter.sv
// Power-up loader: copies the boot word stream into SRAM at ROM_BASE, then hands
// the SRAM to the CPC core and releases its reset after RELEASE_DELAY cycles.
module sram_boot_arbiter
  import sram_boot_pkg::*;
#(
  parameter logic [20:0] ROM_BASE      = 21'h040000,
  parameter int unsigned LOAD_BYTES    = 49152,
  parameter int unsigned RELEASE_DELAY = 16
) (
  input  logic        ck16,
  input  logic        pown_reset_n,
  input  logic [31:0] host_bootdata,
  input  logic        host_bootdata_req,
  output logic        host_bootdata_ack,
  output logic        host_rom_initialised,
  output logic        core_reset_n,
  input  logic [20:0] core_sram_addr,
  input  logic [7:0]  core_sram_dout,
  input  logic        core_sram_we_n,
  output logic [7:0]  core_sram_din,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_data_out,
  output logic        sram_data_oe,
  input  logic [7:0]  sram_data_in,
  output logic        sram_we_n,
  output state_e      dbg_state
);

  // Boot handshake: req is a level meaning "host_bootdata holds a word"; it is
  // only sampled in IDLE. ack pulses one cycle once all bytes of the word are
  // written, and the loader then waits for req to drop before taking another.

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] rel_q, rel_d;
  logic        ack_q, ack_d;
  logic        init_q, init_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        we_n_q, we_n_d;
  logic        oe_q, oe_d;
  logic [20:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  assign cnt_inc = cnt_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    rel_d        = rel_q;
    ack_d        = 1'b0;
    init_d       = init_q;
    core_rst_n_d = core_rst_n_q;
    we_n_d       = 1'b1;
    oe_d         = oe_q;
    addr_d       = addr_q;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        if (cnt_q >= LOAD_BYTES) begin
          state_d = RELEASE;
          init_d  = 1'b1;
          oe_d    = 1'b0;
        end else if (host_bootdata_req) begin
          word_d  = host_bootdata;
          k_d     = 2'd0;
          addr_d  = ROM_BASE + cnt_q[20:0];
          data_d  = host_bootdata[7:0];
          oe_d    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        we_n_d  = 1'b0;
        state_d = STROBE;
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        cnt_d = cnt_inc;
        // Bytes past LOAD_BYTES in the final word are dropped, never strobed.
        if (k_q != 2'(BYTES_PER_WORD - 1) && cnt_inc < LOAD_BYTES) begin
          k_d     = k_q + 2'd1;
          addr_d  = ROM_BASE + cnt_inc[20:0];
          data_d  = byte_sel(word_q, k_q + 2'd1);
          state_d = SETUP;
        end else begin
          ack_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!host_bootdata_req) state_d = IDLE;
      RELEASE: begin
        if (rel_q + 32'd1 >= RELEASE_DELAY) begin
          core_rst_n_d = 1'b1;
          state_d      = DONE;
        end else begin
          rel_d = rel_q + 32'd1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck16 or negedge pown_reset_n) begin
    if (!pown_reset_n) begin
      state_q      <= IDLE;
      word_q       <= 32'd0;
      k_q          <= 2'd0;
      cnt_q        <= 32'd0;
      rel_q        <= 32'd0;
      ack_q        <= 1'b0;
      init_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
      we_n_q       <= 1'b1;
      oe_q         <= 1'b0;
      addr_q       <= ROM_BASE;
      data_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      rel_q        <= rel_d;
      ack_q        <= ack_d;
      init_q       <= init_d;
      core_rst_n_q <= core_rst_n_d;
      we_n_q       <= we_n_d;
      oe_q         <= oe_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign host_bootdata_ack    = ack_q;
  assign host_rom_initialised = init_q;
  assign core_reset_n         = core_rst_n_q;
  assign dbg_state            = state_q;

  boot_sram_mux u_mux (
    .sel_core      (init_q),
    .ld_addr       (addr_q),
    .ld_data       (data_q),
    .ld_oe         (oe_q),
    .ld_we_n       (we_n_q),
    .core_addr     (core_sram_addr),
    .core_dout     (core_sram_dout),
    .core_we_n     (core_sram_we_n),
    .sram_data_in  (sram_data_in),
    .sram_addr     (sram_addr),
    .sram_data_out (sram_data_out),
    .sram_data_oe  (sram_data_oe),
    .sram_we_n     (sram_we_n),
    .core_din      (core_sram_din)
  );

endmodule

// File: tb/tb_sram_boot_arbiter.sv
// Directed bench for sram_boot_arbiter with LOAD_BYTES = 6: per-cycle pin table,
// mux vector table, write scoreboard and hand-written reset/handshake sequences.
module tb_sram_boot_arbiter;
  import sram_boot_pkg::*;

  logic        ck16;
  logic        pown_reset_n;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;
  logic        host_rom_initialised;
  logic        core_reset_n;
  logic [20:0] core_sram_addr;
  logic [7:0]  core_sram_dout;
  logic        core_sram_we_n;
  logic [7:0]  core_sram_din;
  logic [20:0] sram_addr;
  logic [7:0]  sram_data_out;
  logic        sram_data_oe;
  logic [7:0]  sram_data_in;
  logic        sram_we_n;
  state_e      dbg_state;

  sram_boot_arbiter #(
    .ROM_BASE      (21'h040000),
    .LOAD_BYTES    (6),
    .RELEASE_DELAY (16)
  ) dut (
    .ck16                 (ck16),
    .pown_reset_n         (pown_reset_n),
    .host_bootdata        (host_bootdata),
    .host_bootdata_req    (host_bootdata_req),
    .host_bootdata_ack    (host_bootdata_ack),
    .host_rom_initialised (host_rom_initialised),
    .core_reset_n         (core_reset_n),
    .core_sram_addr       (core_sram_addr),
    .core_sram_dout       (core_sram_dout),
    .core_sram_we_n       (core_sram_we_n),
    .core_sram_din        (core_sram_din),
    .sram_addr            (sram_addr),
    .sram_data_out        (sram_data_out),
    .sram_data_oe         (sram_data_oe),
    .sram_data_in         (sram_data_in),
    .sram_we_n            (sram_we_n),
    .dbg_state            (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial ck16 = 1'b0;
  always #5 ck16 = ~ck16;

  initial begin
    #200000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic sb_en = 1'b0;
  logic prev_low = 1'b0;
  logic [28:0] exp_q[$];
  logic [28:0] wr_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every loader write strobe must match the next expected {addr, data}.
  always @(negedge ck16) begin
    if (!pown_reset_n) begin
      prev_low = 1'b0;
    end else begin
      if (host_bootdata_ack) ack_cnt++;
      if (sb_en && !sram_we_n) begin
        check("strobe_width", {63'd0, prev_low}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h@%h required=none", sram_data_out, sram_addr);
        end else begin
          wr_exp = exp_q.pop_front();
          check("sram_write", {34'd0, sram_data_oe, sram_addr, sram_data_out}, {34'd0, 1'b1, wr_exp});
        end
      end
      prev_low = !sram_we_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ck16);
    #1;
  endtask

  // sel: 0 = ack, 1 = host_rom_initialised, 2 = core_reset_n
  task automatic wait_sig(input string name, input int sel, input int max, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < max) begin
      tick();
      n++;
      hit = (sel == 0) ? host_bootdata_ack : (sel == 1) ? host_rom_initialised : core_reset_n;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_event required=event_within_%0d", name, max);
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic        we_n;
    logic        oe;
    logic [20:0] addr;
    logic [7:0]  dout;
    logic        ack;
  } wr_vec_t;

  typedef struct {
    logic [20:0] c_addr;
    logic [7:0]  c_dout;
    logic        c_we_n;
    logic [7:0]  s_in;
    logic [20:0] e_addr;
    logic [7:0]  e_dout;
    logic        e_oe;
    logic        e_we_n;
    logic [7:0]  e_din;
  } mux_vec_t;

  wr_vec_t  wtab[13];
  mux_vec_t mtab[4];
  int n;
  int ack_base;
  logic ack_seen;

  initial begin
    // Cycles 1..13 after req is sampled for word 32'hDDCCBBAA.
    wtab[0]  = '{1'b1, 1'b1, 21'h040000, 8'hAA, 1'b0};
    wtab[1]  = '{1'b0, 1'b1, 21'h040000, 8'hAA, 1'b0};
    wtab[2]  = '{1'b1, 1'b1, 21'h040000, 8'hAA, 1'b0};
    wtab[3]  = '{1'b1, 1'b1, 21'h040001, 8'hBB, 1'b0};
    wtab[4]  = '{1'b0, 1'b1, 21'h040001, 8'hBB, 1'b0};
    wtab[5]  = '{1'b1, 1'b1, 21'h040001, 8'hBB, 1'b0};
    wtab[6]  = '{1'b1, 1'b1, 21'h040002, 8'hCC, 1'b0};
    wtab[7]  = '{1'b0, 1'b1, 21'h040002, 8'hCC, 1'b0};
    wtab[8]  = '{1'b1, 1'b1, 21'h040002, 8'hCC, 1'b0};
    wtab[9]  = '{1'b1, 1'b1, 21'h040003, 8'hDD, 1'b0};
    wtab[10] = '{1'b0, 1'b1, 21'h040003, 8'hDD, 1'b0};
    wtab[11] = '{1'b1, 1'b1, 21'h040003, 8'hDD, 1'b0};
    wtab[12] = '{1'b1, 1'b0, 21'h040003, 8'hDD, 1'b1};
    // Core-side pin vectors once the core owns the SRAM.
    mtab[0] = '{21'h000123, 8'h5A, 1'b0, 8'h77, 21'h000123, 8'h5A, 1'b1, 1'b0, 8'h77};
    mtab[1] = '{21'h000123, 8'h5A, 1'b1, 8'h77, 21'h000123, 8'h5A, 1'b0, 1'b1, 8'h77};
    mtab[2] = '{21'h1FFFFF, 8'h00, 1'b1, 8'h3C, 21'h1FFFFF, 8'h00, 1'b0, 1'b1, 8'h3C};
    mtab[3] = '{21'h0ABCDE, 8'hC3, 1'b0, 8'h00, 21'h0ABCDE, 8'hC3, 1'b1, 1'b0, 8'h00};

    pown_reset_n      = 1'b0;
    host_bootdata     = 32'd0;
    host_bootdata_req = 1'b0;
    core_sram_addr    = 21'h0;
    core_sram_dout    = 8'h00;
    core_sram_we_n    = 1'b1;
    sram_data_in      = 8'h99;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_we_n", {63'd0, sram_we_n}, 64'd1);
    check("rst_oe", {63'd0, sram_data_oe}, 64'd0);
    check("rst_addr", {43'd0, sram_addr}, {43'd0, 21'h040000});
    check("rst_ack", {63'd0, host_bootdata_ack}, 64'd0);
    check("rst_init", {63'd0, host_rom_initialised}, 64'd0);
    check("rst_core_reset_n", {63'd0, core_reset_n}, 64'd0);
    check("rst_core_din", {56'd0, core_sram_din}, {56'd0, 8'hFF});
    check("rst_state", {61'd0, dbg_state}, {61'd0, IDLE});
    pown_reset_n = 1'b1;

    // ---- reset during STROBE of byte 2 ----
    tick();
    host_bootdata     = 32'hDDCCBBAA;
    host_bootdata_req = 1'b1;
    repeat (8) tick();
    check("mid_strobe_we_n", {63'd0, sram_we_n}, 64'd0);
    check("mid_strobe_addr", {43'd0, sram_addr}, {43'd0, 21'h040002});
    #2;
    pown_reset_n = 1'b0;
    #1;
    check("abort_we_n", {63'd0, sram_we_n}, 64'd1);
    check("abort_ack", {63'd0, host_bootdata_ack}, 64'd0);
    check("abort_init", {63'd0, host_rom_initialised}, 64'd0);
    check("abort_addr", {43'd0, sram_addr}, {43'd0, 21'h040000});
    host_bootdata_req = 1'b0;
    tick();
    pown_reset_n = 1'b1;

    // ---- first word, cycle-exact pin table ----
    sb_en = 1'b1;
    exp_q.push_back({21'h040000, 8'hAA});
    exp_q.push_back({21'h040001, 8'hBB});
    exp_q.push_back({21'h040002, 8'hCC});
    exp_q.push_back({21'h040003, 8'hDD});
    tick();
    host_bootdata_req = 1'b1;
    for (int c = 0; c < 13; c++) begin
      tick();
      check($sformatf("word1_cycle%0d", c + 1),
            {32'd0, wtab[c].we_n, wtab[c].oe, wtab[c].addr, wtab[c].dout, wtab[c].ack},
            {32'd0, sram_we_n, sram_data_oe, sram_addr, sram_data_out, host_bootdata_ack} ^
            {32'd0, 32'd0} ^ {32'd0, 32'd0});
    end

    // ---- req held high: same word must not be accepted twice ----
    ack_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (host_bootdata_ack) ack_seen = 1'b1;
    end
    check("held_req_no_ack", {63'd0, ack_seen}, 64'd0);
    check("held_req_state", {61'd0, dbg_state}, {61'd0, WAIT_LOW});
    check("held_req_init", {63'd0, host_rom_initialised}, 64'd0);
    host_bootdata_req = 1'b0;
    tick();
    check("req_low_state", {61'd0, dbg_state}, {61'd0, IDLE});

    // ---- second word: only bytes 05, 06 fit under LOAD_BYTES ----
    exp_q.push_back({21'h040004, 8'h05});
    exp_q.push_back({21'h040005, 8'h06});
    host_bootdata     = 32'h08070605;
    host_bootdata_req = 1'b1;
    wait_sig("word2_ack", 0, 30, n);
    check("word2_ack_latency", 64'(n), 64'd7);
    host_bootdata_req = 1'b0;
    wait_sig("init_rise", 1, 30, n);
    check("init_latency", 64'(n), 64'd3);
    check("core_held_at_init", {63'd0, core_reset_n}, 64'd0);
    wait_sig("core_release", 2, 40, n);
    check("release_delay", 64'(n), 64'd16);
    check("done_state", {61'd0, dbg_state}, {61'd0, DONE});
    check("load1_all_written", 64'(exp_q.size()), 64'd0);

    // ---- core owns the SRAM ----
    sb_en = 1'b0;
    for (int v = 0; v < 4; v++) begin
      core_sram_addr = mtab[v].c_addr;
      core_sram_dout = mtab[v].c_dout;
      core_sram_we_n = mtab[v].c_we_n;
      sram_data_in   = mtab[v].s_in;
      #1;
      check($sformatf("mux_vec%0d", v),
            {25'd0, sram_addr, sram_data_out, sram_data_oe, sram_we_n, core_sram_din},
            {25'd0, mtab[v].e_addr, mtab[v].e_dout, mtab[v].e_oe, mtab[v].e_we_n, mtab[v].e_din});
      tick();
    end
    check("done_sticky", {62'd0, host_rom_initialised, core_reset_n}, 64'd3);
    core_sram_we_n = 1'b1;

    // ---- fresh load with words 04030201, 08070605 ----
    pown_reset_n = 1'b0;
    #1;
    check("reload_rst_init", {63'd0, host_rom_initialised}, 64'd0);
    check("reload_rst_core", {63'd0, core_reset_n}, 64'd0);
    tick();
    pown_reset_n = 1'b1;
    ack_base = ack_cnt;
    sb_en = 1'b1;
    exp_q.push_back({21'h040000, 8'h01});
    exp_q.push_back({21'h040001, 8'h02});
    exp_q.push_back({21'h040002, 8'h03});
    exp_q.push_back({21'h040003, 8'h04});
    exp_q.push_back({21'h040004, 8'h05});
    exp_q.push_back({21'h040005, 8'h06});
    host_bootdata     = 32'h04030201;
    host_bootdata_req = 1'b1;
    wait_sig("load2_w1_ack", 0, 30, n);
    check("load2_w1_latency", 64'(n), 64'd13);
    host_bootdata_req = 1'b0;
    repeat (2) tick();
    check("load2_idle", {61'd0, dbg_state}, {61'd0, IDLE});
    host_bootdata     = 32'h08070605;
    host_bootdata_req = 1'b1;
    wait_sig("load2_w2_ack", 0, 30, n);
    check("load2_w2_latency", 64'(n), 64'd7);
    host_bootdata_req = 1'b0;
    wait_sig("load2_init", 1, 30, n);
    check("load2_init_latency", 64'(n), 64'd3);
    check("load2_ack_count", 64'(ack_cnt - ack_base), 64'd2);
    check("load2_all_written", 64'(exp_q.size()), 64'd0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
